// File: rtl/pong_game_core.sv
// Pong game core: serve/play/point/game-over sequencing, ball physics, paddles and scoring.
// Optional PONG_SPEEDUP_EN: ball |dx| grows by one every four consecutive returns (max 6).
module pong_game_core #(
    parameter int unsigned FRAME_W      = 640,
    parameter int unsigned FRAME_H      = 480,
    parameter int unsigned PADDLE_H     = 64,
    parameter int unsigned PADDLE_X1    = 16,
    parameter int unsigned PADDLE_X2    = 620,
    parameter int unsigned BALL_SIZE    = 8,
    parameter int unsigned PADDLE_SPEED = 4,
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SCORE_W      = 3
) (
    input  logic               CLOCK_25,
    input  logic               reset,
    input  logic               tick,
    input  logic               p1_up,
    input  logic               p1_down,
    input  logic               p2_up,
    input  logic               p2_down,
    input  logic               pause_btn,
    output logic [11:0]        ball_x,
    output logic [11:0]        ball_y,
    output logic [11:0]        p1_y,
    output logic [11:0]        p2_y,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [2:0]         state,
    output logic [1:0]         winner,
    output logic               point_pulse
);
    localparam int unsigned POS_W   = 12;
    localparam int unsigned WIDE_W  = POS_W + 1;
    localparam int unsigned ARITH_W = 14;

    localparam logic [POS_W-1:0]  BALL_X0 = POS_W'((FRAME_W - BALL_SIZE) / 2);
    localparam logic [POS_W-1:0]  BALL_Y0 = POS_W'((FRAME_H - BALL_SIZE) / 2);
    localparam logic [POS_W-1:0]  PAD_Y0  = POS_W'((FRAME_H - PADDLE_H) / 2);
    localparam logic [WIDE_W-1:0] PAD_MAX = WIDE_W'(FRAME_H - PADDLE_H);
    localparam logic [WIDE_W-1:0] PAD_SPD = WIDE_W'(PADDLE_SPEED);
    localparam logic [SCORE_W-1:0] WIN_V  = SCORE_W'(WIN_SCORE);

    localparam logic signed [ARITH_W-1:0] X1_S  = ARITH_W'(PADDLE_X1);
    localparam logic signed [ARITH_W-1:0] X2_S  = ARITH_W'(PADDLE_X2);
    localparam logic signed [ARITH_W-1:0] BS_S  = ARITH_W'(BALL_SIZE);
    localparam logic signed [ARITH_W-1:0] HB_S  = ARITH_W'(BALL_SIZE / 2);
    localparam logic signed [ARITH_W-1:0] FH_S  = ARITH_W'(FRAME_H);
    localparam logic signed [ARITH_W-1:0] PH_S  = ARITH_W'(PADDLE_H);
    localparam logic signed [ARITH_W-1:0] Q1_S  = ARITH_W'(PADDLE_H / 4);
    localparam logic signed [ARITH_W-1:0] Q2_S  = ARITH_W'(PADDLE_H / 2);
    localparam logic signed [ARITH_W-1:0] Q3_S  = ARITH_W'((PADDLE_H / 4) * 3);

    typedef enum logic [2:0] {
        PAUSED   = 3'd0,
        SERVE    = 3'd1,
        PLAY     = 3'd2,
        POINT    = 3'd3,
        GAMEOVER = 3'd4
    } state_t;

    state_t                cur, cur_n, resume, resume_n;
    logic [POS_W-1:0]      ball_x_n, ball_y_n, p1_y_n, p2_y_n, p1_mv, p2_mv;
    logic [SCORE_W-1:0]    score1_n, score2_n;
    logic [1:0]            winner_n;
    logic                  point_pulse_n;
    logic signed [3:0]     dx, dx_n, dy, dy_n, mag_s;
    logic                  server, server_n;
    logic [4:0]            cnt, cnt_n;
    logic [2:0]            mag;
    logic signed [ARITH_W-1:0] bx, by, nx, ny, dxs, dys, off;
    logic                  wall_top, wall_bot, hit_l, hit_r, miss;
`ifdef PONG_SPEEDUP_EN
    logic [2:0]            spd, spd_n;
    logic [1:0]            ret, ret_n;
`endif

    function automatic logic [POS_W-1:0] paddle_step(input logic [POS_W-1:0] y,
                                                     input logic up, input logic down);
        logic [WIDE_W-1:0] yw;
        logic [POS_W-1:0]  res;
        yw  = {1'b0, y};
        res = y;
        if (up)
            res = (yw >= PAD_SPD) ? POS_W'(yw - PAD_SPD) : '0;
        else if (down)
            res = (yw + PAD_SPD >= PAD_MAX) ? POS_W'(PAD_MAX) : POS_W'(yw + PAD_SPD);
        return res;
    endfunction

    function automatic logic [POS_W-1:0] attach(input logic [POS_W-1:0] py);
        return py + POS_W'(PADDLE_H / 2 - BALL_SIZE / 2);
    endfunction

    function automatic logic signed [3:0] abs4(input logic signed [3:0] v);
        return v[3] ? -v : v;
    endfunction

    always_ff @(posedge CLOCK_25) begin
        if (reset) cur <= PAUSED;
        else       cur <= cur_n;
    end

    // Next-state and datapath: pause is handled every cycle, game steps only on tick.
    always_comb begin
        cur_n         = cur;
        resume_n      = resume;
        ball_x_n      = ball_x;
        ball_y_n      = ball_y;
        p1_y_n        = p1_y;
        p2_y_n        = p2_y;
        score1_n      = score1;
        score2_n      = score2;
        winner_n      = winner;
        point_pulse_n = 1'b0;
        dx_n          = dx;
        dy_n          = dy;
        server_n      = server;
        cnt_n         = cnt;
        p1_mv         = paddle_step(p1_y, p1_up, p1_down);
        p2_mv         = paddle_step(p2_y, p2_up, p2_down);
        bx            = ARITH_W'(ball_x);
        by            = ARITH_W'(ball_y);
        dxs           = ARITH_W'(dx);
        dys           = ARITH_W'(dy);
        nx            = bx + dxs;
        ny            = by + dys;
        off           = '0;
        wall_top      = 1'b0;
        wall_bot      = 1'b0;
        hit_l         = 1'b0;
        hit_r         = 1'b0;
        miss          = 1'b0;
`ifdef PONG_SPEEDUP_EN
        spd_n         = spd;
        ret_n         = ret;
        mag           = (ret == 2'd3 && spd < 3'd6) ? spd + 3'd1 : spd;
`else
        mag           = 3'd2;
`endif
        mag_s         = $signed({1'b0, mag});

        case (cur)
            PAUSED: begin
                if (pause_btn) cur_n = resume;
            end
            SERVE, PLAY: begin
                if (pause_btn) begin
                    resume_n = cur;
                    cur_n    = PAUSED;
                end else if (tick) begin
                    p1_y_n = p1_mv;
                    p2_y_n = p2_mv;
                    if (cur == SERVE) begin
                        ball_x_n = BALL_X0;
                        ball_y_n = attach(server ? p2_y : p1_y);
                        dx_n     = server ? -4'sd2 : 4'sd2;
                        dy_n     = 4'sd0;
                        cur_n    = PLAY;
`ifdef PONG_SPEEDUP_EN
                        spd_n    = 3'd2;
                        ret_n    = 2'd0;
`endif
                    end else begin
                        if (dy[3] && by <= -dys) begin
                            wall_top = 1'b1;
                            ny       = '0;
                        end else if (!dy[3] && dy != 4'sd0 && by + BS_S >= FH_S - dys) begin
                            wall_bot = 1'b1;
                            ny       = FH_S - BS_S;
                        end
                        hit_l = dx[3] && bx > X1_S && nx <= X1_S;
                        hit_r = !dx[3] && dx != 4'sd0 && bx + BS_S < X2_S && nx + BS_S >= X2_S;
                        if (hit_l) begin
                            nx  = X1_S;
                            off = by + HB_S - ARITH_W'(p1_y);
                        end else if (hit_r) begin
                            nx  = X2_S - BS_S;
                            off = by + HB_S - ARITH_W'(p2_y);
                        end
                        miss = (hit_l || hit_r) && (off[ARITH_W-1] || off >= PH_S);
                        // Return: paddle quarter picks the new vertical speed.
                        if ((hit_l || hit_r) && !miss) begin
                            if (off < Q1_S)      dy_n = -4'sd2;
                            else if (off < Q2_S) dy_n = -4'sd1;
                            else if (off < Q3_S) dy_n = 4'sd1;
                            else                 dy_n = 4'sd2;
                            dx_n = hit_l ? mag_s : -mag_s;
`ifdef PONG_SPEEDUP_EN
                            spd_n = mag;
                            ret_n = ret + 2'd1;
`endif
                        end
                        if (wall_top)      dy_n = abs4(dy_n);
                        else if (wall_bot) dy_n = -abs4(dy_n);
                        ball_x_n = POS_W'(nx);
                        ball_y_n = POS_W'(ny);
                        if (miss) begin
                            point_pulse_n = 1'b1;
                            cur_n         = POINT;
                            cnt_n         = '0;
                            if (hit_l) begin
                                score2_n = score2 + SCORE_W'(1);
                                server_n = 1'b0;
                            end else begin
                                score1_n = score1 + SCORE_W'(1);
                                server_n = 1'b1;
                            end
                        end
                    end
                end
            end
            POINT: begin
                if (tick) begin
                    p1_y_n = p1_mv;
                    p2_y_n = p2_mv;
                    cnt_n  = cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        cnt_n = '0;
                        if (score1 == WIN_V || score2 == WIN_V) begin
                            cur_n    = GAMEOVER;
                            winner_n = (score1 == WIN_V) ? 2'd1 : 2'd2;
                        end else begin
                            cur_n    = SERVE;
                            ball_x_n = BALL_X0;
                            ball_y_n = attach(server ? p2_y : p1_y);
                        end
                    end
                end
            end
            GAMEOVER: begin
                if (pause_btn) begin
                    score1_n = '0;
                    score2_n = '0;
                    winner_n = 2'd0;
                    server_n = 1'b0;
                    cur_n    = SERVE;
                    ball_x_n = BALL_X0;
                    ball_y_n = attach(p1_y);
                end
            end
            default: cur_n = PAUSED;
        endcase
    end

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            resume      <= SERVE;
            ball_x      <= BALL_X0;
            ball_y      <= BALL_Y0;
            p1_y        <= PAD_Y0;
            p2_y        <= PAD_Y0;
            score1      <= '0;
            score2      <= '0;
            winner      <= 2'd0;
            point_pulse <= 1'b0;
            dx          <= 4'sd2;
            dy          <= 4'sd0;
            server      <= 1'b0;
            cnt         <= '0;
`ifdef PONG_SPEEDUP_EN
            spd         <= 3'd2;
            ret         <= 2'd0;
`endif
        end else begin
            resume      <= resume_n;
            ball_x      <= ball_x_n;
            ball_y      <= ball_y_n;
            p1_y        <= p1_y_n;
            p2_y        <= p2_y_n;
            score1      <= score1_n;
            score2      <= score2_n;
            winner      <= winner_n;
            point_pulse <= point_pulse_n;
            dx          <= dx_n;
            dy          <= dy_n;
            server      <= server_n;
            cnt         <= cnt_n;
`ifdef PONG_SPEEDUP_EN
            spd         <= spd_n;
            ret         <= ret_n;
`endif
        end
    end

    assign state = cur;
endmodule
